// File: rtl/port_reader_if.sv
// File-register read bus between the ALU data-in mux (master) and port_reader (slave).
interface port_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rdEn;
  logic [4:0]            rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;

  modport master (output rdEn, rdAddr, input  rdData, rdValid);
  modport slave  (input  rdEn, rdAddr, output rdData, rdValid);
endinterface

// File: rtl/port_reader.sv
// Pad synchronisers for PORTA/B/C, file-register read-back of the synchronised pins,
// and sticky change detection on PORTB input pins for wake/interrupt use.
module port_reader #(
  parameter int IO_A_WIDTH  = 4,
  parameter int IO_B_WIDTH  = 8,
  parameter int IO_C_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_A_WIDTH-1:0] padA,
  input  logic [IO_B_WIDTH-1:0] padB,
  input  logic [IO_C_WIDTH-1:0] padC,
  input  logic [IO_B_WIDTH-1:0] trisB,
  port_reader_if.slave          bus,
  input  logic                  changeEn,
  output logic                  changeFlag,
  output logic                  changeIrq
);

  typedef enum logic [4:0] {
    ADDR_PORTA = 5'd5,
    ADDR_PORTB = 5'd6,
    ADDR_PORTC = 5'd7
  } portAddr_e;

  logic [SYNC_STAGES-1:0][IO_A_WIDTH-1:0] shA;
  logic [SYNC_STAGES-1:0][IO_B_WIDTH-1:0] shB;
  logic [SYNC_STAGES-1:0][IO_C_WIDTH-1:0] shC;
  logic [IO_A_WIDTH-1:0] syncA;
  logic [IO_B_WIDTH-1:0] syncB;
  logic [IO_C_WIDTH-1:0] syncC;

  logic                  portHit;
  logic                  portBRead;
  logic [DATA_WIDTH-1:0] portVal;
  logic [DATA_WIDTH-1:0] rdDataQ;
  logic                  rdValidQ;

  logic [IO_B_WIDTH-1:0] snapshot;
  logic                  snapValid;
  logic                  inputChanged;

  // Stage 0 samples the pad; the last stage is the only one safe to consume.
  // NOTE: non-blocking assignments let every stage take its predecessor's old value on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shA <= '0;
      shB <= '0;
      shC <= '0;
    end else begin
      shA <= {shA[SYNC_STAGES-2:0], padA};
      shB <= {shB[SYNC_STAGES-2:0], padB};
      shC <= {shC[SYNC_STAGES-2:0], padC};
    end
  end

  assign syncA = shA[SYNC_STAGES-1];
  assign syncB = shB[SYNC_STAGES-1];
  assign syncC = shC[SYNC_STAGES-1];

  // NOTE: defaults first so that no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    portHit = 1'b0;
    portVal = '0;
    if (bus.rdEn) begin
      case (bus.rdAddr)
        ADDR_PORTA: begin portHit = 1'b1; portVal = DATA_WIDTH'(syncA); end
        ADDR_PORTB: begin portHit = 1'b1; portVal = DATA_WIDTH'(syncB); end
        ADDR_PORTC: begin portHit = 1'b1; portVal = DATA_WIDTH'(syncC); end
        default:    ;
      endcase
    end
  end

  assign portBRead = bus.rdEn && (bus.rdAddr == ADDR_PORTB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdDataQ  <= '0;
      rdValidQ <= 1'b0;
    end else begin
      rdValidQ <= portHit;
      if (portHit) rdDataQ <= portVal;
    end
  end

  assign bus.rdData  = rdDataQ;
  assign bus.rdValid = rdValidQ;

  // Only input pins (trisB=1) are compared; output pins never raise the flag.
  assign inputChanged = |((syncB ^ snapshot) & trisB);

  // A PORTB read re-arms the detector; its clear beats a same-edge mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot   <= '0;
      snapValid  <= 1'b0;
      changeFlag <= 1'b0;
    end else if (portBRead) begin
      snapshot   <= syncB;
      snapValid  <= 1'b1;
      changeFlag <= 1'b0;
    end else if (snapValid && inputChanged) begin
      changeFlag <= 1'b1;
    end
  end

  assign changeIrq = changeFlag & changeEn;

endmodule

// File: tb/tb_port_reader.sv
// Directed bench for port_reader: reset, sync latency, addressing, PORTB change
// detection, clear/set collision, TRIS-driven set and asynchronous reset mid-read.
module tb_port_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] padA = '0;
  logic [7:0] padB = '0;
  logic [7:0] padC = '0;
  logic [7:0] trisB = '0;
  logic       changeEn = 1'b0;
  logic       changeFlag;
  logic       changeIrq;

  int nCompared   = 0;
  int nMismatched = 0;

  port_reader_if #(.DATA_WIDTH(8)) bus ();

  port_reader #(
    .IO_A_WIDTH(4), .IO_B_WIDTH(8), .IO_C_WIDTH(8), .DATA_WIDTH(8), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .padA       (padA),
    .padB       (padB),
    .padC       (padC),
    .trisB      (trisB),
    .bus        (bus),
    .changeEn   (changeEn),
    .changeFlag (changeFlag),
    .changeIrq  (changeIrq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    padB = 8'hFF; trisB = 8'hFF; changeEn = 1'b1;
    bus.rdEn = 1'b0; bus.rdAddr = 5'd0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    nCompared++;
    if (bus.rdData !== 8'h00) begin
      nMismatched++; $display("FAIL reset_rdData: got %h want 00", bus.rdData);
    end
    nCompared++;
    if (bus.rdValid !== 1'b0) begin
      nMismatched++; $display("FAIL reset_rdValid: got %b want 0", bus.rdValid);
    end
    nCompared++;
    if (changeFlag !== 1'b0 || changeIrq !== 1'b0) begin
      nMismatched++; $display("FAIL reset_flag: got flag=%b irq=%b want 0/0", changeFlag, changeIrq);
    end
    changeEn = 1'b0;
  endtask

  // Back-to-back PORTC reads: a pulse every cycle, new pad value on the third.
  task automatic test_latency;
    logic [7:0] expData;
    padC = 8'h00;
    tick(3);
    padC = 8'hA5; bus.rdEn = 1'b1; bus.rdAddr = 5'd7;
    for (int k = 1; k <= 4; k++) begin
      tick();
      expData = (k >= 3) ? 8'hA5 : 8'h00;
      nCompared++;
      if (bus.rdValid !== 1'b1 || bus.rdData !== expData) begin
        nMismatched++;
        $display("FAIL latency_cycle%0d: got valid=%b data=%h want 1/%h", k, bus.rdValid, bus.rdData, expData);
      end
    end
    bus.rdEn = 1'b0;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b0) begin
      nMismatched++; $display("FAIL latency_idle_valid: got %b want 0", bus.rdValid);
    end
  endtask

  task automatic test_addr;
    padA = 4'hF;
    tick(3);
    bus.rdEn = 1'b1; bus.rdAddr = 5'd5;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b1 || bus.rdData !== 8'h0F) begin
      nMismatched++; $display("FAIL addr5_read: got valid=%b data=%h want 1/0f", bus.rdValid, bus.rdData);
    end
    bus.rdAddr = 5'd4;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b0 || bus.rdData !== 8'h0F) begin
      nMismatched++; $display("FAIL addr4_read: got valid=%b data=%h want 0/0f", bus.rdValid, bus.rdData);
    end
    bus.rdAddr = 5'd8;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b0 || bus.rdData !== 8'h0F) begin
      nMismatched++; $display("FAIL addr8_read: got valid=%b data=%h want 0/0f", bus.rdValid, bus.rdData);
    end
    bus.rdEn = 1'b0;
  endtask

  task automatic test_change;
    trisB = 8'h0F; padB = 8'h00;
    tick(3);
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL change_unarmed: got %b want 0", changeFlag);
    end
    bus.rdEn = 1'b1; bus.rdAddr = 5'd6;
    tick();
    bus.rdEn = 1'b0;
    nCompared++;
    if (bus.rdValid !== 1'b1 || bus.rdData !== 8'h00) begin
      nMismatched++; $display("FAIL change_arm_read: got valid=%b data=%h want 1/00", bus.rdValid, bus.rdData);
    end
    padB = 8'h10;
    tick(4);
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL change_output_pin: got %b want 0", changeFlag);
    end
    padB = 8'h11;
    tick(2);
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL change_early: got %b want 0", changeFlag);
    end
    tick();
    nCompared++;
    if (changeFlag !== 1'b1 || changeIrq !== 1'b0) begin
      nMismatched++; $display("FAIL change_set: got flag=%b irq=%b want 1/0", changeFlag, changeIrq);
    end
    changeEn = 1'b1;
    #1;
    nCompared++;
    if (changeIrq !== 1'b1) begin
      nMismatched++; $display("FAIL change_irq: got %b want 1", changeIrq);
    end
    tick(2);
    nCompared++;
    if (changeFlag !== 1'b1) begin
      nMismatched++; $display("FAIL change_sticky: got %b want 1", changeFlag);
    end
    bus.rdEn = 1'b1; bus.rdAddr = 5'd6;
    tick();
    bus.rdEn = 1'b0;
    nCompared++;
    if (changeFlag !== 1'b0 || changeIrq !== 1'b0 || bus.rdData !== 8'h11) begin
      nMismatched++;
      $display("FAIL change_clear: got flag=%b irq=%b data=%h want 0/0/11", changeFlag, changeIrq, bus.rdData);
    end
    tick();
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL change_rearmed: got %b want 0", changeFlag);
    end
  endtask

  // The read lands on the very edge where the mismatch first becomes visible.
  task automatic test_collision;
    padB = 8'h10;
    tick(2);
    bus.rdEn = 1'b1; bus.rdAddr = 5'd6;
    tick();
    bus.rdEn = 1'b0;
    nCompared++;
    if (changeFlag !== 1'b0 || bus.rdData !== 8'h10) begin
      nMismatched++; $display("FAIL collision_clear: got flag=%b data=%h want 0/10", changeFlag, bus.rdData);
    end
    tick();
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL collision_after: got %b want 0", changeFlag);
    end
    padB = 8'h11;
    tick(2);
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL collision_early: got %b want 0", changeFlag);
    end
    tick();
    nCompared++;
    if (changeFlag !== 1'b1) begin
      nMismatched++; $display("FAIL collision_reset_flag: got %b want 1", changeFlag);
    end
  endtask

  task automatic test_tris;
    bus.rdEn = 1'b1; bus.rdAddr = 5'd6;
    tick();
    bus.rdEn = 1'b0;
    padB = 8'h31;
    tick(4);
    nCompared++;
    if (changeFlag !== 1'b0) begin
      nMismatched++; $display("FAIL tris_output_change: got %b want 0", changeFlag);
    end
    trisB = 8'h3F;
    tick();
    nCompared++;
    if (changeFlag !== 1'b1) begin
      nMismatched++; $display("FAIL tris_now_input: got %b want 1", changeFlag);
    end
  endtask

  task automatic test_async_reset;
    bus.rdEn = 1'b1; bus.rdAddr = 5'd7;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b1 || bus.rdData !== 8'hA5 || changeFlag !== 1'b1) begin
      nMismatched++;
      $display("FAIL async_pre: got valid=%b data=%h flag=%b want 1/a5/1", bus.rdValid, bus.rdData, changeFlag);
    end
    #2 rst = 1'b1;
    #1;
    nCompared++;
    if (bus.rdValid !== 1'b0 || bus.rdData !== 8'h00 || changeFlag !== 1'b0 || changeIrq !== 1'b0) begin
      nMismatched++;
      $display("FAIL async_mid: got valid=%b data=%h flag=%b irq=%b want 0/00/0/0",
               bus.rdValid, bus.rdData, changeFlag, changeIrq);
    end
    tick();
    bus.rdEn = 1'b0;
    #2 rst = 1'b0;
    tick();
    nCompared++;
    if (bus.rdValid !== 1'b0 || bus.rdData !== 8'h00 || changeFlag !== 1'b0) begin
      nMismatched++;
      $display("FAIL async_release: got valid=%b data=%h flag=%b want 0/00/0", bus.rdValid, bus.rdData, changeFlag);
    end
  endtask

  initial begin
    bus.rdEn = 1'b0;
    bus.rdAddr = 5'd0;
    test_reset();
    test_latency();
    test_addr();
    test_change();
    test_collision();
    test_tris();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
